gsplat_tile_fetch: RTL and testbench

//  Walks the per-frame linked list of tile descriptors in DDR3 ahead of tile dispatch.

---
 rtl/gsplat_tile_fetch.sv | 255 +++++++++++++++++++++++++
 tb/tb_gsplat_tile_fetch.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsplat_tile_fetch.sv
// ============================================================================
// Module   : gsplat_tile_fetch
// Brief    : Walks the DDR3 tile-descriptor linked list and queues parsed
//            headers in a small first-word-fall-through FIFO for the dispatcher.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gsplat_tile_fetch #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [15:0] MAX_TILES = 16'd4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [28:0] first_addr,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] tile_count,
    output logic [28:0] rd_addr,
    output logic [7:0]  rd_burstcnt,
    output logic        rd_req,
    input  logic        rd_ack,
    input  logic [63:0] rd_data,
    input  logic        rd_data_valid,
    output logic        desc_valid,
    input  logic        desc_ready,
    output logic [28:0] desc_addr,
    output logic [15:0] desc_px,
    output logic [15:0] desc_py,
    output logic [15:0] desc_count,
    output logic        desc_last
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = 78;
    localparam logic [AW:0] c_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ZERO  = 3'd1,
        S_REQ   = 3'd2,
        S_BEAT0 = 3'd3,
        S_BEAT1 = 3'd4,
        S_DRAIN = 3'd5,
        S_FLUSH = 3'd6
    } state_t;

    state_t        r_state;
    logic [28:0]   r_cur;
    logic [28:0]   r_next;
    logic          r_rd_req;
    logic          r_done;
    logic          r_err;
    logic [15:0]   r_tile_count;
    logic [1:0]    r_flush_left;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_desc_valid;
    logic          w_has_slot;
    logic [EW-1:0] w_push_data;
    logic [EW-1:0] w_head;
    logic [2:0]    w_unused_bits;

    assign w_unused_bits = rd_data[63:61];

    assign w_desc_valid = (r_count != '0);
    assign w_has_slot   = (r_count < c_FULL);
    assign w_flush      = abort;
    assign w_pop        = w_desc_valid & desc_ready;
    assign w_push       = (r_state == S_BEAT1) & rd_data_valid & ~abort;
    // Entry layout: {addr, px, py, count, last}
    assign w_push_data  = {r_cur, rd_data[31:16], rd_data[47:32], rd_data[15:0],
                           (r_next == 29'd0)};
    assign w_head       = r_mem[r_rptr];

    // ------------------------------------------------------------------
    // Descriptor FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; outputs are gated by occupancy below.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    // ------------------------------------------------------------------
    // List-walk FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cur        <= '0;
            r_next       <= '0;
            r_rd_req     <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_tile_count <= '0;
            r_flush_left <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort && !w_desc_valid) begin
                        r_tile_count <= '0;
                        r_err        <= 1'b0;
                        if (first_addr != 29'd0) begin
                            r_cur   <= first_addr;
                            r_state <= S_REQ;
                        end else begin
                            r_state <= S_ZERO;
                        end
                    end
                end

                // Empty list: finish without touching memory.
                S_ZERO: begin
                    if (!abort) begin
                        r_done <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end

                S_REQ: begin
                    if (abort) begin
                        r_rd_req <= 1'b0;
                        if (r_rd_req && rd_ack) begin
                            r_flush_left <= 2'd2;
                            r_state      <= S_FLUSH;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (r_rd_req) begin
                        if (rd_ack) begin
                            r_rd_req <= 1'b0;
                            r_state  <= S_BEAT0;
                        end
                    end else if (w_has_slot) begin
                        // Only request when the FIFO can take the header.
                        r_rd_req <= 1'b1;
                    end
                end

                S_BEAT0: begin
                    if (abort) begin
                        r_flush_left <= rd_data_valid ? 2'd1 : 2'd2;
                        r_state      <= S_FLUSH;
                    end else if (rd_data_valid) begin
                        r_next  <= rd_data[60:32];
                        r_state <= S_BEAT1;
                    end
                end

                S_BEAT1: begin
                    if (abort) begin
                        if (rd_data_valid) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_flush_left <= 2'd1;
                            r_state      <= S_FLUSH;
                        end
                    end else if (rd_data_valid) begin
                        r_tile_count <= r_tile_count + 16'd1;
                        if (r_next == 29'd0) begin
                            r_state <= S_DRAIN;
                        end else if ((r_tile_count + 16'd1) == MAX_TILES) begin
                            r_err   <= 1'b1;
                            r_state <= S_DRAIN;
                        end else begin
                            r_cur   <= r_next;
                            r_state <= S_REQ;
                        end
                    end
                end

                S_DRAIN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (!w_desc_valid) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end

                // Swallow beats of a read that was accepted before abort.
                S_FLUSH: begin
                    if (rd_data_valid) begin
                        r_flush_left <= r_flush_left - 2'd1;
                        if (r_flush_left == 2'd1) begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy        = (r_state != S_IDLE) | w_desc_valid;
    assign done        = r_done;
    assign err         = r_err;
    assign tile_count  = r_tile_count;
    assign rd_addr     = r_cur;
    assign rd_burstcnt = 8'd2;
    assign rd_req      = r_rd_req;

    assign desc_valid  = w_desc_valid;
    assign desc_addr   = w_desc_valid ? w_head[77:49] : 29'd0;
    assign desc_px     = w_desc_valid ? w_head[48:33] : 16'd0;
    assign desc_py     = w_desc_valid ? w_head[32:17] : 16'd0;
    assign desc_count  = w_desc_valid ? w_head[16:1]  : 16'd0;
    assign desc_last   = w_desc_valid & w_head[0];

endmodule

`default_nettype wire

// File: tb/tb_gsplat_tile_fetch.sv
// ============================================================================
// Module   : tb_gsplat_tile_fetch
// Brief    : Scoreboard bench for gsplat_tile_fetch with a DDR3 read responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gsplat_tile_fetch;

    // Guard kept small so the self-loop case stays short.
    localparam logic [15:0] TB_MAX = 16'd9;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [28:0] first_addr = '0;
    logic        abort = 1'b0;
    logic        rd_ack = 1'b0;
    logic [63:0] rd_data = '0;
    logic        rd_data_valid = 1'b0;
    logic        desc_ready = 1'b0;

    logic        busy, done, err, rd_req, desc_valid, desc_last;
    logic [15:0] tile_count, desc_px, desc_py, desc_count;
    logic [28:0] rd_addr, desc_addr;
    logic [7:0]  rd_burstcnt;

    gsplat_tile_fetch #(.DEPTH(4), .MAX_TILES(TB_MAX)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .first_addr(first_addr),
        .abort(abort), .busy(busy), .done(done), .err(err), .tile_count(tile_count),
        .rd_addr(rd_addr), .rd_burstcnt(rd_burstcnt), .rd_req(rd_req), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .desc_valid(desc_valid),
        .desc_ready(desc_ready), .desc_addr(desc_addr), .desc_px(desc_px),
        .desc_py(desc_py), .desc_count(desc_count), .desc_last(desc_last)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] mem [int unsigned];
    logic [77:0] sb [$];

    int hold = 1;
    int ack_lat = 1, beat_lat = 2, beat_gap = 0;
    int ack_cnt = 0, beats_sent = 0, done_cnt = 0, dv_cycles = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mem_rd(input int unsigned k);
        if (mem.exists(k)) return mem[k];
        return 64'd0;
    endfunction

    task automatic write_tile(input logic [28:0] a, input logic [28:0] nxt,
                              input logic [15:0] px, input logic [15:0] py, input logic [15:0] cnt);
        mem[32'(a)]     = {3'b101, nxt, 3'b000, a};
        mem[32'(a) + 1] = {16'hFACE, py, px, cnt};
    endtask

    task automatic exp_push(input logic [28:0] a, input logic [15:0] px, input logic [15:0] py,
                            input logic [15:0] cnt, input logic last);
        sb.push_back({a, px, py, cnt, last});
    endtask

    task automatic add_tile(input logic [28:0] a, input logic [28:0] nxt,
                            input logic [15:0] px, input logic [15:0] py, input logic [15:0] cnt);
        write_tile(a, nxt, px, py, cnt);
        exp_push(a, px, py, cnt, nxt == 29'd0);
    endtask

    task automatic kick(input logic [28:0] a);
        @(negedge clk);
        first_addr = a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string tag);
        int i = 0;
        while (done_cnt == d0 && i < 400) begin
            @(negedge clk);
            i++;
        end
        check(tag, 128'(done_cnt != d0), 128'd1);
    endtask

    function automatic logic [127:0] out_vec();
        return {busy, done, err, tile_count, rd_addr, rd_req, desc_valid,
                desc_addr, desc_px, desc_py, desc_count, desc_last};
    endfunction

    // DDR3 responder: ack after ack_lat, then two beats from the model memory.
    initial begin : g_responder
        int rs = 0;
        int wcnt = 0;
        logic [28:0] raddr = '0;
        logic [28:0] req_addr = '0;
        forever begin
            @(negedge clk);
            rd_ack = 1'b0;
            rd_data_valid = 1'b0;
            if (!reset_n) begin
                rs = 0;
                wcnt = 0;
            end else begin
                if (rs != 0 && rd_req) check("one_outstanding", 128'd1, 128'd0);
                case (rs)
                    0: if (rd_req) begin
                        if (wcnt == 0) req_addr = rd_addr;
                        else check("rd_addr_stable", 128'(rd_addr), 128'(req_addr));
                        if (wcnt >= ack_lat) begin
                            rd_ack = 1'b1;
                            raddr = rd_addr;
                            ack_cnt++;
                            check("burstcnt", 128'(rd_burstcnt), 128'd2);
                            rs = 1;
                            wcnt = 0;
                        end else wcnt++;
                    end else wcnt = 0;
                    1: if (wcnt >= beat_lat) begin
                        rd_data_valid = 1'b1;
                        rd_data = mem_rd(32'(raddr));
                        beats_sent++;
                        rs = 2;
                        wcnt = 0;
                    end else wcnt++;
                    default: if (wcnt >= beat_gap) begin
                        rd_data_valid = 1'b1;
                        rd_data = mem_rd(32'(raddr) + 1);
                        beats_sent++;
                        rs = 0;
                        wcnt = 0;
                    end else wcnt++;
                endcase
            end
        end
    end

    // Consumer: pops whenever not held and compares against the scoreboard.
    initial begin : g_consumer
        logic [77:0] exp;
        forever begin
            @(negedge clk);
            desc_ready = (hold == 0);
            if (desc_valid && desc_ready) begin
                if (sb.size() == 0) begin
                    check("desc_unexpected", 128'd1, 128'd0);
                end else begin
                    exp = sb.pop_front();
                    check("desc", 128'({desc_addr, desc_px, desc_py, desc_count, desc_last}),
                          128'(exp));
                end
            end
        end
    end

    initial begin : g_monitor
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (desc_valid) dv_cycles++;
        end
    end

    initial begin : g_watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : g_main
        int d0, a0, b0, v0, i;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 128'd0);
        check("reset_burstcnt", 128'(rd_burstcnt), 128'd2);
        reset_n = 1'b1;
        hold = 0;

        // 1: three-tile list, no backpressure
        add_tile(29'h100, 29'h200, 16'd16, 16'd32, 16'd7);
        add_tile(29'h200, 29'h300, 16'd48, 16'd32, 16'd0);
        add_tile(29'h300, 29'h000, 16'd64, 16'd96, 16'hFFFF);
        d0 = done_cnt;
        kick(29'h100);
        wait_done(d0, "t1_done");
        repeat (4) @(negedge clk);
        check("t1_all_popped", 128'(sb.size()), 128'd0);
        check("t1_tile_count", 128'(tile_count), 128'd3);
        check("t1_done_once", 128'(done_cnt - d0), 128'd1);
        check("t1_err", 128'(err), 128'd0);
        check("t1_busy", 128'(busy), 128'd0);

        // 2: eight tiles with consumer stalled
        hold = 1;
        for (int k = 0; k < 8; k++)
            add_tile(29'h1000 + 29'(k * 16), (k == 7) ? 29'd0 : 29'h1000 + 29'((k + 1) * 16),
                     16'(k * 8), 16'(100 + k), 16'(k * 3 + 1));
        a0 = ack_cnt;
        d0 = done_cnt;
        kick(29'h1000);
        repeat (80) @(negedge clk);
        check("t2_acks_stalled", 128'(ack_cnt - a0), 128'd4);
        check("t2_no_req_full", 128'(rd_req), 128'd0);
        check("t2_desc_valid", 128'(desc_valid), 128'd1);
        check("t2_count_stalled", 128'(tile_count), 128'd4);
        check("t2_no_done", 128'(done_cnt - d0), 128'd0);
        hold = 0;
        wait_done(d0, "t2_done");
        repeat (4) @(negedge clk);
        check("t2_all_popped", 128'(sb.size()), 128'd0);
        check("t2_acks", 128'(ack_cnt - a0), 128'd8);
        check("t2_tile_count", 128'(tile_count), 128'd8);

        // 3: empty list
        d0 = done_cnt; a0 = ack_cnt; v0 = dv_cycles;
        kick(29'd0);
        check("t3_done_early", 128'(done), 128'd0);
        @(negedge clk);
        check("t3_done_at_2", 128'(done), 128'd1);
        repeat (8) @(negedge clk);
        check("t3_done_once", 128'(done_cnt - d0), 128'd1);
        check("t3_no_req", 128'(ack_cnt - a0), 128'd0);
        check("t3_no_desc", 128'(dv_cycles - v0), 128'd0);
        check("t3_tile_count", 128'(tile_count), 128'd0);

        // 4a: self-loop hits the list-length guard
        write_tile(29'h5000, 29'h5000, 16'd5, 16'd6, 16'd77);
        for (int k = 0; k < 9; k++) exp_push(29'h5000, 16'd5, 16'd6, 16'd77, 1'b0);
        d0 = done_cnt;
        kick(29'h5000);
        wait_done(d0, "t4_done");
        repeat (4) @(negedge clk);
        check("t4_err", 128'(err), 128'd1);
        check("t4_tile_count", 128'(tile_count), 128'(TB_MAX));
        check("t4_all_popped", 128'(sb.size()), 128'd0);
        check("t4_done_once", 128'(done_cnt - d0), 128'd1);

        // 4b: list ending exactly at the guard length is not an error
        for (int k = 0; k < 9; k++)
            add_tile(29'h5100 + 29'(k * 16), (k == 8) ? 29'd0 : 29'h5100 + 29'((k + 1) * 16),
                     16'(k), 16'(k + 1), 16'(k + 2));
        d0 = done_cnt;
        kick(29'h5100);
        check("t4b_err_cleared", 128'(err), 128'd0);
        wait_done(d0, "t4b_done");
        repeat (4) @(negedge clk);
        check("t4b_err", 128'(err), 128'd0);
        check("t4b_tile_count", 128'(tile_count), 128'd9);
        check("t4b_all_popped", 128'(sb.size()), 128'd0);

        // 5: abort after rd_ack, before the beats arrive
        beat_lat = 8;
        write_tile(29'h6000, 29'h6100, 16'd1, 16'd2, 16'd3);
        write_tile(29'h6100, 29'h0000, 16'd4, 16'd5, 16'd6);
        a0 = ack_cnt; d0 = done_cnt; v0 = dv_cycles; b0 = beats_sent;
        kick(29'h6000);
        i = 0;
        while (ack_cnt == a0 && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("t5_ack_seen", 128'(ack_cnt - a0), 128'd1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (25) @(negedge clk);
        check("t5_beats_swallowed", 128'(beats_sent - b0), 128'd2);
        check("t5_no_desc", 128'(dv_cycles - v0), 128'd0);
        check("t5_no_done", 128'(done_cnt - d0), 128'd0);
        check("t5_one_ack", 128'(ack_cnt - a0), 128'd1);
        check("t5_idle", 128'({busy, rd_req}), 128'd0);
        beat_lat = 2;
        add_tile(29'h7000, 29'h7100, 16'd11, 16'd12, 16'd13);
        add_tile(29'h7100, 29'h0000, 16'd14, 16'd15, 16'd16);
        d0 = done_cnt;
        kick(29'h7000);
        wait_done(d0, "t5_restart_done");
        repeat (4) @(negedge clk);
        check("t5_all_popped", 128'(sb.size()), 128'd0);
        check("t5_tile_count", 128'(tile_count), 128'd2);

        // 6: reset while in BEAT1 with two descriptors queued
        hold = 1;
        beat_gap = 8;
        for (int k = 0; k < 4; k++)
            write_tile(29'h8000 + 29'(k * 16), (k == 3) ? 29'd0 : 29'h8000 + 29'((k + 1) * 16),
                       16'(k), 16'(k), 16'(k));
        b0 = beats_sent;
        kick(29'h8000);
        i = 0;
        while ((beats_sent - b0) < 5 && i < 300) begin
            @(negedge clk);
            i++;
        end
        check("t6_reached_beat1", 128'(beats_sent - b0), 128'd5);
        @(negedge clk);
        check("t6_pre_fifo", 128'({desc_valid, tile_count}), 128'({1'b1, 16'd2}));
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_reset_outputs", out_vec(), 128'd0);
        check("t6_reset_burstcnt", 128'(rd_burstcnt), 128'd2);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        beat_gap = 0;
        hold = 0;
        add_tile(29'h9000, 29'h9100, 16'd21, 16'd22, 16'd23);
        add_tile(29'h9100, 29'h9200, 16'd24, 16'd25, 16'd26);
        add_tile(29'h9200, 29'h0000, 16'd27, 16'd28, 16'd29);
        d0 = done_cnt;
        kick(29'h9000);
        wait_done(d0, "t6_done");
        repeat (4) @(negedge clk);
        check("t6_all_popped", 128'(sb.size()), 128'd0);
        check("t6_tile_count", 128'(tile_count), 128'd3);
        check("t6_done_once", 128'(done_cnt - d0), 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
